// File: rtl/regs_arb_pkg.sv
// Shared types and constants for the register-port access arbiter.
package regs_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } arb_state_e;

  localparam int unsigned DATA_W = 32;
  localparam logic        RD     = 1'b0;
  localparam logic        WR     = 1'b1;

  // Timeout counter width: enough to hold the limit, never narrower than 4 bits.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return ($clog2(timeout + 1) < 4) ? 4 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/regs_access_arb_if.sv
// Register block port bundle; the arbiter drives it through the master modport.
interface regs_access_arb_if
  import regs_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE_P = 4
) ();

  logic [ADDR_SIZE_P-1:0] addr;
  logic                   rd_wr;
  logic                   req;
  logic [DATA_W-1:0]      write_val;
  logic [DATA_W-1:0]      read_val;
  logic                   ack;

  modport master (
    output addr,
    output rd_wr,
    output req,
    output write_val,
    input  read_val,
    input  ack
  );

  modport slave (
    input  addr,
    input  rd_wr,
    input  req,
    input  write_val,
    output read_val,
    output ack
  );

endinterface

// File: rtl/regs_rr_arb.sv
// Combinational round-robin grant: first requester at or above ptr_i, wrapping.
module regs_rr_arb #(
  parameter int unsigned NUM_REQ_P = 2,
  parameter int unsigned PTR_W     = 1
) (
  input  logic [NUM_REQ_P-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_REQ_P-1:0] gnt_o
);

  // One spare bit so ptr + offset never overflows before the wrap.
  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(NUM_REQ_P)) begin
        idx = idx - (PTR_W + 1)'(NUM_REQ_P);
      end
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_access_arb.sv
// Round-robin arbiter sharing one register block port among NUM_REQ_P requesters.
// Define REGS_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_P cycles with req_err_o.
module regs_access_arb
  import regs_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE_P = 4,
  parameter int unsigned NUM_REQ_P   = 2,
  parameter int unsigned TIMEOUT_P   = 15
) (
  input  logic                                  clk,
  input  logic                                  reset_L,
  input  logic [NUM_REQ_P-1:0]                  req_i,
  input  logic [NUM_REQ_P-1:0][ADDR_SIZE_P-1:0] req_addr_i,
  input  logic [NUM_REQ_P-1:0]                  req_rd_wr_i,
  input  logic [NUM_REQ_P-1:0][DATA_W-1:0]      req_wdata_i,
  output logic [NUM_REQ_P-1:0]                  req_ack_o,
  output logic [DATA_W-1:0]                     req_rdata_o,
  output logic                                  req_err_o,
  output logic                                  busy_o,
  regs_access_arb_if.master                     bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ_P);

  if (NUM_REQ_P < 2 || NUM_REQ_P > 4) begin : g_bad_num_req
    $error("regs_access_arb: NUM_REQ_P must be 2..4");
  end
  if (TIMEOUT_P == 0) begin : g_bad_timeout
    $error("regs_access_arb: TIMEOUT_P must be nonzero");
  end

  arb_state_e             state_q, state_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [PtrW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [ADDR_SIZE_P-1:0] addr_q, addr_d;
  logic                   rd_wr_q, rd_wr_d;
  logic                   breq_q, breq_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NUM_REQ_P-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_REQ_P-1:0]   gnt_oh;
  logic [PtrW-1:0]        gnt_idx;
  logic [NUM_REQ_P-1:0]   held_oh;

`ifdef REGS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = cnt_width(TIMEOUT_P);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  regs_rr_arb #(
    .NUM_REQ_P (NUM_REQ_P),
    .PTR_W     (PtrW)
  ) u_rr_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ_P; i++) begin
      if (gnt_oh[i]) gnt_idx = PtrW'(i);
    end
  end

  assign held_oh = NUM_REQ_P'(1) << gnt_idx_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    addr_d    = addr_q;
    rd_wr_d   = rd_wr_q;
    breq_d    = breq_q;
    wdata_d   = wdata_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
`ifdef REGS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          gnt_idx_d = gnt_idx;
          addr_d    = req_addr_i[gnt_idx];
          rd_wr_d   = req_rd_wr_i[gnt_idx];
          wdata_d   = req_wdata_i[gnt_idx];
          breq_d    = 1'b1;
          state_d   = StWait;
`ifdef REGS_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StWait: begin
        if (bus.ack) begin
          breq_d  = 1'b0;
          rdata_d = (rd_wr_q == WR) ? '0 : bus.read_val;
          ack_d   = held_oh;
          state_d = StResp;
`ifdef REGS_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT_P - 1)) begin
          breq_d  = 1'b0;
          rdata_d = '0;
          ack_d   = held_oh;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
`endif
        end
      end
      StResp: begin
        ptr_d   = (gnt_idx_q == PtrW'(NUM_REQ_P - 1)) ? '0 : gnt_idx_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      rd_wr_q   <= 1'b0;
      breq_q    <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
`ifdef REGS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      addr_q    <= addr_d;
      rd_wr_q   <= rd_wr_d;
      breq_q    <= breq_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
`ifdef REGS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.addr      = addr_q;
  assign bus.rd_wr     = rd_wr_q;
  assign bus.req       = breq_q;
  assign bus.write_val = wdata_q;
  assign req_ack_o     = ack_q;
  assign req_rdata_o   = rdata_q;
  assign busy_o        = (state_q != StIdle);
`ifdef REGS_ARB_TIMEOUT_EN
  assign req_err_o     = err_q;
`else
  assign req_err_o     = 1'b0;
`endif

endmodule

// File: doc/regs_access_arb.md
# regs_access_arb

Round-robin arbiter that shares the single register block port (addr, rd_wr, req, write_val, read_val, ack) between NUM_REQ_P independent requesters (e.g. host CPU and debug/test agent). Serializes accesses, holds one transaction outstanding at a time, returns read data and a completion pulse to the granted requester. Sits directly in front of the register block; register-block timing is unchanged.

## Interface
- ADDR_SIZE_P, 4, register address width (matches register block)
- NUM_REQ_P, 2, number of requesters (2..4)
- TIMEOUT_P, 15, cycles to wait for register ack before error (used only with timeout feature)

- clk  in  1  single clock, all logic rising-edge
- reset_L  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ_P  per-requester request, level, held until its ack
- req_addr_i  in  NUM_REQ_P x ADDR_SIZE_P  per-requester address
- req_rd_wr_i  in  NUM_REQ_P  per-requester direction, 1 = write, 0 = read
- req_wdata_i  in  NUM_REQ_P x 32  per-requester write data
- req_ack_o  out  NUM_REQ_P  one-cycle completion pulse to granted requester
- req_rdata_o  out  32  read data, valid only while a req_ack_o bit is high
- req_err_o  out  1  timeout error, valid with req_ack_o
- busy_o  out  1  transaction in flight (state != IDLE)
- addr  out  ADDR_SIZE_P  to register block
- rd_wr  out  1  to register block, same encoding as req_rd_wr_i
- req  out  1  to register block
- write_val  out  32  to register block
- read_val  in  32  from register block
- ack  in  1  from register block, single-cycle pulse

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_i bit high, grant via round-robin starting at pointer; latch granted addr/rd_wr/wdata into addr/rd_wr/write_val; assert req; -> WAIT. Else stay.
- WAIT: hold req and latched fields stable. On ack: capture read_val (reads only; writes capture 0), drop req, -> RESP.
- RESP: pulse req_ack_o[grant] with req_rdata_o/req_err_o; pointer <= grant+1 mod NUM_REQ_P; -> IDLE.
- Requester rule: deassert req_i on the edge at which it samples its ack; req_i changes of non-granted requesters never affect the in-flight transaction.
- ack seen in IDLE or RESP: ignored.
- Requester data inputs of granted requester are sampled only at grant edge.

## Timing
- Reset values: req_ack_o 0, req_rdata_o 0, req_err_o 0, busy_o 0, req 0, addr 0, rd_wr 0, write_val 0; pointer 0; state IDLE.
- req_i sampled high at edge 0 -> req high from edge 0 (cycle 1); register ack in cycle k -> req low and req_ack_o high in cycle k+1; IDLE again cycle k+2. Minimum turnaround 3 cycles per access.
- One idle cycle always separates consecutive register transactions.
- Simultaneous requests: lowest index at or above pointer wins, wrapping.
- reset_L low mid-transaction: all state/outputs to reset values immediately; in-flight access abandoned, no ack issued.

## Configuration
- REGS_ARB_TIMEOUT_EN defined: 4-bit-min counter (width clog2(TIMEOUT_P+1)) clears on entry to WAIT, increments each WAIT cycle; reaching TIMEOUT_P without ack -> drop req, -> RESP with req_err_o=1, req_rdata_o=0. Late ack afterwards ignored.
- Undefined: no counter, WAIT waits indefinitely, req_err_o tied 0.

## Structure
- Package regs_arb_pkg: state enum (IDLE, WAIT, RESP), DATA_W=32, RD=1'b0/WR=1'b1 encodings.
- Sub-module regs_rr_arb: combinational round-robin grant (one-hot) from request vector and pointer; pointer register stays in top.

## Test plan
- Single read: req_i=01, addr 4'h3, read_val 32'h0000_00A5 with ack 2 cycles after req -> req_ack_o=01 one cycle, req_rdata_o=32'hA5, req_err_o=0.
- Single write: requester 1 write addr 4'h1 data 32'h1234_5678 -> addr=1, rd_wr=1, write_val=32'h12345678 held until ack; req_ack_o=10, req_rdata_o=0.
- Contention: req_i=11 held continuously, ack after 1 cycle each -> grants alternate 0,1,0,1; no requester served twice consecutively.
- Timeout (REGS_ARB_TIMEOUT_EN, TIMEOUT_P=15): no ack -> req drops after 15 WAIT cycles, req_ack_o pulse with req_err_o=1; subsequent late ack ignored, busy_o=0.
- Reset mid-WAIT: reset_L low while req=1 -> all outputs 0 asynchronously, pointer 0; after release, request from 1 with req_i=11 grants requester 0 first.
- Spurious ack in IDLE: ack pulse with req_i=0 -> no req_ack_o, state stays IDLE.
